// File: rtl/uart_tx_core.sv
// uart_tx_core
//   Frame serialiser for the serial transmit path. Takes parallel words over a
//   valid/ready handshake and shifts them out as start bit, DATA_BITS data
//   bits (LSB first) and STOP_BITS stop bits. Bit timing comes from a
//   one-cycle baud strobe supplied by the upstream divider; everything runs
//   on the single system clock.
//
// Ports
//   clk_in    system clock, all state on the rising edge
//   rst       synchronous reset, active-high
//   baud_en   one-cycle strobe per bit period (may be held high)
//   tx_data   word to transmit, sampled only at acceptance
//   tx_valid  tx_data is valid
//   tx_ready  block can accept a word this cycle (high only while idle)
//   tx        registered serial line, idle high
//   busy      a frame is pending or in progress
module uart_tx_core #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int               IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;

  // Handshake flags are pure decodes of the state register, so tx_ready
  // drops the cycle after acceptance and returns the cycle after the last
  // stop strobe.
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // The line level is loaded together with the state transition, so each
  // new level appears the cycle after the baud strobe that caused it.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          // A strobe coinciding with acceptance is deliberately ignored.
          if (tx_valid) begin
            shift <= tx_data;
            state <= ALIGN;
          end
        end

        // Wait for a fresh strobe so the start bit gets a full period.
        ALIGN: begin
          if (baud_en) begin
            state <= START;
            tx    <= 1'b0;
          end
        end

        START: begin
          if (baud_en) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end

        DATA: begin
          if (baud_en) begin
            if (bit_idx == LAST_IDX) begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
            end else begin
              // shift[1] becomes shift[0] after this shift, so present it now.
              shift   <= shift >> 1;
              bit_idx <= bit_idx + IDX_W'(1);
              tx      <= shift[1];
            end
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (baud_en) begin
            if (stop_cnt != LAST_STOP) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Serial-path transmitter directly downstream of the serial clock divider.
- Consumes a one-cycle bit-rate strobe (baud_en) derived from the divider.
- Serialises parallel bytes into 8N1-style frames (start, DATA_BITS LSB-first, STOP_BITS stop) on a single system clock; no generated clocks.
- Upstream byte source connects via valid/ready handshake.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bits per frame (1 or 2; other values illegal).

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- baud_en  input  1  one-cycle strobe per bit period; may be asserted in any cycle.
- tx_data  input  DATA_BITS  byte to send; sampled only at acceptance.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line, idle high; registered.
- busy  output  1  frame pending or in progress.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, tx=1, tx_ready=1, busy=0, shift register and counters cleared. Reset mid-frame aborts: tx=1 from the next cycle, and no partial bits are resumed.
- Acceptance: tx_valid && tx_ready at a posedge. tx_data is latched into the shift register and state goes to ALIGN. tx_ready=1 only in IDLE; busy = (state != IDLE). Both are registered/derived from state, so tx_ready drops the cycle after acceptance.
- baud_en in the acceptance cycle is ignored.
- States:
  - IDLE: tx=1. Acceptance -> ALIGN.
  - ALIGN: tx=1. Waits for the first baud_en. On baud_en -> START.
  - START: tx=0. On baud_en -> DATA, bit index=0.
  - DATA: tx=shift[0].
    - On baud_en with index < DATA_BITS-1: shift right, index+1.
    - On baud_en with index == DATA_BITS-1: -> STOP, stop count=0.
  - STOP: tx=1.
    - On baud_en with count < STOP_BITS-1: count+1.
    - Otherwise -> IDLE.
- tx is registered from the state and shift register; each line level changes the cycle after the baud_en that caused the transition.
- Every bit therefore lasts exactly one baud_en interval. ALIGN guarantees the start bit is full-length.
- Frame length in baud_en pulses after acceptance: 1 (align) + 1 + DATA_BITS + STOP_BITS.
- Back-to-back: tx_ready returns the cycle after the final stop baud_en. A byte accepted that cycle enters ALIGN, and its start bit begins at the next baud_en. The line therefore stays high for exactly one baud period between frames, beyond the configured stop bits.
- tx_valid while busy is held off (no acceptance); the upstream holds tx_data.
- Changes to tx_data after acceptance have no effect on the frame in flight.
- baud_en held high continuously: advances one state/bit per cycle (legal, used for fast sim).
- Bit index width: $clog2(DATA_BITS); stop count width 1.

Test Plan:
- Bench pulses baud_en every 4 cycles. Reset, then send tx_data=0x55 -> tx stays 1 until the first baud_en after acceptance, then over 40 cycles shows 0,1,0,1,0,1,0,1,0,1 (4 cycles each). tx_ready=0 / busy=1 throughout; tx_ready=1 one cycle after the 10th bit-period baud_en.
- Back-to-back 0xA3 then 0x0F with tx_valid held continuously -> frame 1 = 0,1,1,0,0,0,1,0,1,1 and frame 2 = 0,1,1,1,1,0,0,0,0,1. Exactly one extra idle-high baud period between the frames; tx_data sampled only at each acceptance.
- Accept 0xFF, then drive tx_data=0x00 with tx_valid=1 mid-frame -> no second acceptance while busy; frame still 0 followed by nine 1s; 0x00 accepted the cycle tx_ready returns.
- Assert rst for one cycle during data bit 3 of 0x00 -> tx=1, tx_ready=1, busy=0 the next cycle. A new 0x81 sent afterwards produces a clean full frame 0,1,0,0,0,0,0,0,1,1.
- STOP_BITS=2, baud_en tied high, send 0x01 -> tx per cycle after ALIGN: 0,1,0,0,0,0,0,0,0,1,1, then tx_ready=1 on the next cycle.
- Acceptance coincident with baud_en -> that strobe is ignored, and the start bit begins only after the next baud_en (full-length start bit verified by cycle count).
